// File: rtl/cache_bank_scheduler_pkg.sv
// Shared constants for the cache bank scheduler: default widths, FIFO depth and router port indices.
package cache_bank_scheduler_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_NET_W  = 4;
    localparam int DEF_DATA_W = 16;

    localparam int CACHE_SCHED_QDEPTH = 4;

    typedef enum logic [1:0] {
        PORT_NORTH = 2'd0,
        PORT_SOUTH = 2'd1,
        PORT_EAST  = 2'd2,
        PORT_WEST  = 2'd3
    } portIdx_t;

    // Round-robin scan position; wraps naturally in two bits.
    function automatic logic [1:0] portAdd(input logic [1:0] base, input logic [1:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/cache_req_fifo.sv
// Single-clock request FIFO; head is read straight from the entry registers, so
// an entry is visible to the scheduler the cycle after it is pushed.
module cache_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW:0]      count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    assign head  = mem[rdPtr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/cache_bank_scheduler.sv
// Round-robin scheduler sharing one dual-port cache bank between four requester FIFOs.
// Define CACHE_SCHED_STATS_EN to add the stat_issued/stat_conflict/stat_full counters.
module cache_bank_scheduler
    import cache_bank_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NET_W   = DEF_NET_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int QDEPTH  = CACHE_SCHED_QDEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sched_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*NET_W-1:0]  req_src,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0]         bank_addr_a,
    output logic [DATA_W-1:0]         bank_wdata_a,
    output logic                      bank_we_n_a,
    input  logic [DATA_W-1:0]         bank_rdata_a,
    output logic [ADDR_W-1:0]         bank_addr_b,
    output logic [DATA_W-1:0]         bank_wdata_b,
    output logic                      bank_we_n_b,
    input  logic [DATA_W-1:0]         bank_rdata_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*NET_W-1:0]  rsp_src,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data
`ifdef CACHE_SCHED_STATS_EN
    ,
    output logic [15:0]               stat_issued,
    output logic [15:0]               stat_conflict,
    output logic [15:0]               stat_full
`endif
);
    localparam int EW = 1 + ADDR_W + NET_W + DATA_W;

    logic [NUM_REQ-1:0] fifoFull, fifoEmpty, fifoPush, fifoPop;
    logic [EW-1:0]      fifoHead  [NUM_REQ];
    logic               headWrite [NUM_REQ];
    logic [ADDR_W-1:0]  headAddr  [NUM_REQ];
    logic [NET_W-1:0]   headSrc   [NUM_REQ];
    logic [DATA_W-1:0]  headWdata [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gReq
            assign fifoPush[gi]  = req_valid[gi] && !fifoFull[gi];
            assign req_ready[gi] = !fifoFull[gi];

            cache_req_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) uFifo (
                .clk      (clk),
                .reset    (reset),
                .push     (fifoPush[gi]),
                .pushData ({req_write[gi], req_addr[gi*ADDR_W +: ADDR_W],
                            req_src[gi*NET_W +: NET_W], req_wdata[gi*DATA_W +: DATA_W]}),
                .pop      (fifoPop[gi]),
                .full     (fifoFull[gi]),
                .empty    (fifoEmpty[gi]),
                .head     (fifoHead[gi])
            );

            assign {headWrite[gi], headAddr[gi], headSrc[gi], headWdata[gi]} = fifoHead[gi];
        end
    endgenerate

    logic [1:0] rrPtr;
    logic [1:0] firstIdx, secondIdx;
    logic       firstHit, secondHit;
    logic       conflict, issueA, issueB;

    always_comb begin
        logic [1:0] idx;
        idx       = '0;
        firstHit  = 1'b0;
        secondHit = 1'b0;
        firstIdx  = '0;
        secondIdx = '0;
        for (int k = 0; k < 4; k++) begin
            idx = portAdd(rrPtr, 2'(k));
            if (!fifoEmpty[idx]) begin
                if (!firstHit) begin
                    firstHit = 1'b1;
                    firstIdx = idx;
                end else if (!secondHit) begin
                    secondHit = 1'b1;
                    secondIdx = idx;
                end
            end
        end
    end

    // Same-address pairs involving a write are serialised to keep bank ordering intact.
    assign conflict = firstHit && secondHit && (headAddr[firstIdx] == headAddr[secondIdx])
                      && (headWrite[firstIdx] || headWrite[secondIdx]);
    assign issueA   = sched_en && firstHit;
    assign issueB   = sched_en && secondHit && !conflict;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gPop
            assign fifoPop[gi] = (issueA && firstIdx == 2'(gi)) || (issueB && secondIdx == 2'(gi));
        end
    endgenerate

    logic             tagValidA, tagValidB;
    logic [1:0]       tagPortA, tagPortB;
    logic [NET_W-1:0] tagSrcA, tagSrcB;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rrPtr        <= '0;
            bank_addr_a  <= '0;
            bank_wdata_a <= '0;
            bank_we_n_a  <= 1'b1;
            bank_addr_b  <= '0;
            bank_wdata_b <= '0;
            bank_we_n_b  <= 1'b1;
            tagValidA    <= 1'b0;
            tagValidB    <= 1'b0;
            tagPortA     <= '0;
            tagPortB     <= '0;
            tagSrcA      <= '0;
            tagSrcB      <= '0;
            rsp_valid    <= '0;
            rsp_src      <= '0;
            rsp_data     <= '0;
        end else begin
            if (issueA) rrPtr <= (issueB ? secondIdx : firstIdx) + 2'd1;

            bank_we_n_a <= 1'b1;
            tagValidA   <= issueA && !headWrite[firstIdx];
            if (issueA) begin
                bank_addr_a  <= headAddr[firstIdx];
                bank_wdata_a <= headWdata[firstIdx];
                bank_we_n_a  <= ~headWrite[firstIdx];
                tagPortA     <= firstIdx;
                tagSrcA      <= headSrc[firstIdx];
            end

            bank_we_n_b <= 1'b1;
            tagValidB   <= issueB && !headWrite[secondIdx];
            if (issueB) begin
                bank_addr_b  <= headAddr[secondIdx];
                bank_wdata_b <= headWdata[secondIdx];
                bank_we_n_b  <= ~headWrite[secondIdx];
                tagPortB     <= secondIdx;
                tagSrcB      <= headSrc[secondIdx];
            end

            // Tags always name distinct ports, so both responses can land in one cycle.
            rsp_valid <= '0;
            if (tagValidA) begin
                rsp_valid[tagPortA]                 <= 1'b1;
                rsp_src[tagPortA*NET_W +: NET_W]    <= tagSrcA;
                rsp_data[tagPortA*DATA_W +: DATA_W] <= bank_rdata_a;
            end
            if (tagValidB) begin
                rsp_valid[tagPortB]                 <= 1'b1;
                rsp_src[tagPortB*NET_W +: NET_W]    <= tagSrcB;
                rsp_data[tagPortB*DATA_W +: DATA_W] <= bank_rdata_b;
            end
        end
    end

`ifdef CACHE_SCHED_STATS_EN
    logic [1:0] issuedNow;
    assign issuedNow = {1'b0, issueA} + {1'b0, issueB};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_issued   <= '0;
            stat_conflict <= '0;
            stat_full     <= '0;
        end else begin
            if (stat_issued > 16'hFFFF - 16'(issuedNow)) stat_issued <= 16'hFFFF;
            else                                         stat_issued <= stat_issued + 16'(issuedNow);
            if (sched_en && conflict && stat_conflict != 16'hFFFF)
                stat_conflict <= stat_conflict + 16'd1;
            if (|(req_valid & ~req_ready) && stat_full != 16'hFFFF)
                stat_full <= stat_full + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_bank_scheduler.sv
// Directed bench for cache_bank_scheduler with a bank memory model and a response scoreboard.
// Builds with or without CACHE_SCHED_STATS_EN.
module tb_cache_bank_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        sched_en;
    logic [3:0]  req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [15:0] req_src;
    logic [63:0] req_wdata;
    logic [7:0]  bank_addr_a, bank_addr_b;
    logic [15:0] bank_wdata_a, bank_wdata_b, bank_rdata_a, bank_rdata_b;
    logic        bank_we_n_a, bank_we_n_b;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_src;
    logic [63:0] rsp_data;
`ifdef CACHE_SCHED_STATS_EN
    logic [15:0] stat_issued, stat_conflict, stat_full;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  port;
        logic [3:0]  src;
        logic [15:0] data;
    } rsp_t;
    rsp_t expQ[$];

    always #5 clk = ~clk;

    cache_bank_scheduler #(.NUM_REQ(4), .ADDR_W(8), .NET_W(4), .DATA_W(16), .QDEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .sched_en     (sched_en),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_src      (req_src),
        .req_wdata    (req_wdata),
        .bank_addr_a  (bank_addr_a),
        .bank_wdata_a (bank_wdata_a),
        .bank_we_n_a  (bank_we_n_a),
        .bank_rdata_a (bank_rdata_a),
        .bank_addr_b  (bank_addr_b),
        .bank_wdata_b (bank_wdata_b),
        .bank_we_n_b  (bank_we_n_b),
        .bank_rdata_b (bank_rdata_b),
        .rsp_valid    (rsp_valid),
        .rsp_src      (rsp_src),
        .rsp_data     (rsp_data)
`ifdef CACHE_SCHED_STATS_EN
        ,
        .stat_issued   (stat_issued),
        .stat_conflict (stat_conflict),
        .stat_full     (stat_full)
`endif
    );

    // Bank model: synchronous write, read data follows the registered address.
    logic [15:0] bankMem [256];
    bit          memInitDone = 1'b0;

    function automatic logic [15:0] initVal(input logic [7:0] a);
        return (a == 8'h05) ? 16'hCAFE : 16'hA000 + {8'h00, a};
    endfunction

    always @(posedge clk) begin
        if (!memInitDone) begin
            for (int i = 0; i < 256; i++) bankMem[i] <= initVal(8'(i));
            memInitDone <= 1'b1;
        end else begin
            if (!bank_we_n_a) bankMem[bank_addr_a] <= bank_wdata_a;
            if (!bank_we_n_b) bankMem[bank_addr_b] <= bank_wdata_b;
        end
    end
    assign bank_rdata_a = bankMem[bank_addr_a];
    assign bank_rdata_b = bankMem[bank_addr_b];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) begin
                if (rsp_valid[p]) begin
                    rsp_t e;
                    check("rsp_expected", 32'(expQ.size() > 0), 32'd1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        check("rsp_port", 32'(p), 32'(e.port));
                        check("rsp_src", 32'(rsp_src[p*4 +: 4]), 32'(e.src));
                        check("rsp_data", 32'(rsp_data[p*16 +: 16]), 32'(e.data));
                        $display("rsp port=%0d src=0x%0h data=0x%0h", p, rsp_src[p*4 +: 4], rsp_data[p*16 +: 16]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int p, input logic w, input logic [7:0] a,
                          input logic [3:0] s, input logic [15:0] d);
        req_write[p]        = w;
        req_addr[p*8 +: 8]  = a;
        req_src[p*4 +: 4]   = s;
        req_wdata[p*16 +: 16] = d;
    endtask

    task automatic resetDut();
        reset = 1'b0;
        expQ.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0; sched_en = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_src = '0; req_wdata = '0;

        // Reset state
        repeat (2) tick();
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_we_n_a", 32'(bank_we_n_a), 32'h1);
        check("reset_we_n_b", 32'(bank_we_n_b), 32'h1);
        check("reset_addr_a", 32'(bank_addr_a), 32'h0);
        reset = 1'b1;
        tick();
        check("reset_ready", 32'(req_ready), 32'hF);
        $display("txn reset release ready=0x%0h", req_ready);

        // Single read: port 2, addr 0x05, src 0x3
        setReq(2, 1'b0, 8'h05, 4'h3, 16'h0);
        req_valid = 4'b0100;
        expQ.push_back('{port: 2'd2, src: 4'h3, data: 16'hCAFE});
        tick();                                   // E0
        req_valid = '0;
        tick();                                   // E1
        check("single_addr_a", 32'(bank_addr_a), 32'h05);
        check("single_we_n_a", 32'(bank_we_n_a), 32'h1);
        check("single_we_n_b", 32'(bank_we_n_b), 32'h1);
        tick();                                   // E2
        check("single_rsp_valid", 32'(rsp_valid), 32'h4);
        $display("txn single read addr=0x05 rsp_valid=0x%0h", rsp_valid);
        tick();
        check("single_rsp_pulse", 32'(rsp_valid), 32'h0);

        // Four writes in one cycle from rr_ptr=0
        resetDut();
        for (int p = 0; p < 4; p++) setReq(p, 1'b1, 8'(8'h20 + p), 4'(p), 16'(16'h1000 + p));
        req_valid = 4'b1111;
        tick();                                   // E0
        req_valid = '0;
        tick();                                   // E1
        check("wr4_e1_addr_a", 32'(bank_addr_a), 32'h20);
        check("wr4_e1_we_n_a", 32'(bank_we_n_a), 32'h0);
        check("wr4_e1_addr_b", 32'(bank_addr_b), 32'h21);
        check("wr4_e1_we_n_b", 32'(bank_we_n_b), 32'h0);
        tick();                                   // E2
        check("wr4_e2_addr_a", 32'(bank_addr_a), 32'h22);
        check("wr4_e2_addr_b", 32'(bank_addr_b), 32'h23);
        check("wr4_e2_wdata_b", 32'(bank_wdata_b), 32'h1003);
        check("wr4_e2_rsp", 32'(rsp_valid), 32'h0);
        tick();
        check("wr4_idle_we_n_a", 32'(bank_we_n_a), 32'h1);
        check("wr4_idle_hold_addr_a", 32'(bank_addr_a), 32'h22);
        $display("txn four writes done");

        // Fairness: ports 0 and 3 continuously valid, rr_ptr back at 0
        req_valid = 4'b1001;
        for (int k = 0; k < 6; k++) begin
            setReq(0, 1'b1, 8'(8'h40 + k), 4'h0, 16'(16'h2000 + k));
            setReq(3, 1'b1, 8'(8'h80 + k), 4'h3, 16'(16'h3000 + k));
            tick();
            if (k > 0) begin
                check("rr_addr_a", 32'(bank_addr_a), 32'(8'h40 + k - 1));
                check("rr_addr_b", 32'(bank_addr_b), 32'(8'h80 + k - 1));
                check("rr_we_n_b", 32'(bank_we_n_b), 32'h0);
                $display("txn fairness cycle %0d A=0x%0h B=0x%0h", k, bank_addr_a, bank_addr_b);
            end
        end
        req_valid = '0;
        tick();
        check("rr_last_addr_a", 32'(bank_addr_a), 32'h45);
        check("rr_last_addr_b", 32'(bank_addr_b), 32'h85);

        // Conflict: port 0 writes 0x10, port 1 reads 0x10
        resetDut();
        setReq(0, 1'b1, 8'h10, 4'h0, 16'h1234);
        setReq(1, 1'b0, 8'h10, 4'h7, 16'h0);
        req_valid = 4'b0011;
        expQ.push_back('{port: 2'd1, src: 4'h7, data: 16'h1234});
        tick();                                   // E0
        req_valid = '0;
        tick();                                   // E1
        check("conf_e1_addr_a", 32'(bank_addr_a), 32'h10);
        check("conf_e1_we_n_a", 32'(bank_we_n_a), 32'h0);
        check("conf_e1_we_n_b", 32'(bank_we_n_b), 32'h1);
        tick();                                   // E2
        check("conf_e2_addr_a", 32'(bank_addr_a), 32'h10);
        check("conf_e2_we_n_a", 32'(bank_we_n_a), 32'h1);
        check("conf_e2_we_n_b", 32'(bank_we_n_b), 32'h1);
        tick();                                   // E3
        check("conf_rsp_valid", 32'(rsp_valid), 32'h2);
        $display("txn conflict rsp_valid=0x%0h", rsp_valid);
`ifdef CACHE_SCHED_STATS_EN
        check("stat_conflict", 32'(stat_conflict), 32'd1);
        check("stat_issued", 32'(stat_issued), 32'd2);
`endif
        tick();

        // Backpressure on port 1 with scheduling held
        resetDut();
        sched_en  = 1'b0;
        req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            setReq(1, 1'b0, 8'(8'h50 + k), 4'(k), 16'h0);
            expQ.push_back('{port: 2'd1, src: 4'(k), data: initVal(8'(8'h50 + k))});
            tick();
        end
        check("bp_ready_full", 32'(req_ready), 32'hD);
        setReq(1, 1'b0, 8'h54, 4'h4, 16'h0);
        expQ.push_back('{port: 2'd1, src: 4'h4, data: initVal(8'h54)});
        tick();
        check("bp_ready_held", 32'(req_ready), 32'hD);
        check("bp_no_issue", 32'(bank_we_n_a), 32'h1);
        check("bp_no_rsp", 32'(rsp_valid), 32'h0);
        sched_en = 1'b1;
        tick();                                   // first pop
        check("bp_pop0_addr_a", 32'(bank_addr_a), 32'h50);
        check("bp_ready_return", 32'(req_ready), 32'hF);
        tick();                                   // fifth request pushed here
        req_valid = '0;
        check("bp_pop1_addr_a", 32'(bank_addr_a), 32'h51);
        for (int k = 2; k < 5; k++) begin
            tick();
            check("bp_pop_addr_a", 32'(bank_addr_a), 32'(8'h50 + k));
            $display("txn backpressure pop addr=0x%0h", bank_addr_a);
        end
        repeat (3) tick();
        check("bp_queue_drained", 32'(expQ.size()), 32'd0);

        // Reset mid-traffic: two reads in flight, two still queued
        for (int p = 0; p < 4; p++) setReq(p, 1'b0, 8'(8'h60 + p), 4'(p), 16'h0);
        req_valid = 4'b1111;
        tick();                                   // E0
        req_valid = '0;
        tick();                                   // E1
        #1 reset = 1'b0;
        expQ.delete();
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_we_n_a", 32'(bank_we_n_a), 32'h1);
        check("midrst_we_n_b", 32'(bank_we_n_b), 32'h1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("midrst_ready", 32'(req_ready), 32'hF);
        repeat (4) tick();
        check("midrst_idle_we_n_a", 32'(bank_we_n_a), 32'h1);
        $display("txn mid-traffic reset done");

        check("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
